// File: rtl/dispatch_pkg.sv
// Shared definitions for the instruction fetch/dispatch sequencer:
// opcodes, FSM states, fault codes and the opcode-to-executor map.
package dispatch_pkg;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_ALUI_A = 4'h1;
    localparam logic [3:0] OP_ALUI_B = 4'h2;
    localparam logic [3:0] OP_ALUR   = 4'h3;
    localparam logic [3:0] OP_LD     = 4'h4;
    localparam logic [3:0] OP_ST     = 4'h5;
    localparam logic [3:0] OP_HALT   = 4'hF;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_REQ,
        S_FETCH_WAIT,
        S_DECODE,
        S_EXEC,
        S_WAIT_DONE,
        S_HALTED,
        S_FAULT
    } state_e;

    typedef enum logic [1:0] {
        CLS_NOP,
        CLS_EXEC,
        CLS_HALT,
        CLS_ILLEGAL
    } op_cls_e;

    typedef struct packed {
        op_cls_e    cls;
        logic [1:0] idx;
    } op_info_t;

    function automatic op_info_t op_class(input logic [3:0] opcode);
        op_info_t info;
        info.cls = CLS_ILLEGAL;
        info.idx = 2'd0;
        case (opcode)
            OP_NOP:               info.cls = CLS_NOP;
            OP_ALUI_A, OP_ALUI_B: begin info.cls = CLS_EXEC; info.idx = 2'd0; end
            OP_ALUR:              begin info.cls = CLS_EXEC; info.idx = 2'd1; end
            OP_LD, OP_ST:         begin info.cls = CLS_EXEC; info.idx = 2'd2; end
            OP_HALT:              info.cls = CLS_HALT;
            default:              info.cls = CLS_ILLEGAL;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/dispatch_pc_reg.sv
// Program counter: jump load wins over increment; increment wraps naturally.
module dispatch_pc_reg #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            load,
    input  logic [PC_W-1:0] load_val,
    input  logic            inc,
    output logic [PC_W-1:0] pc
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= '0;
        end else if (en) begin
            if (load)
                pc <= load_val;
            else if (inc)
                pc <= pc + PC_W'(1);
        end
    end

endmodule

// File: rtl/instr_dispatch_fsm.sv
// Fetch/decode/dispatch sequencer: fetches into ir, starts one execute FSM,
// waits (bounded) for its done pulse, then fetches the next word.
module instr_dispatch_fsm
    import dispatch_pkg::*;
#(
    parameter int PC_W     = 8,
    parameter int NUM_EXEC = 3,
    parameter int TIMEOUT  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    output logic [PC_W-1:0]     mem_addr,
    output logic                mem_rd_req,
    input  logic                mem_rd_valid,
    input  logic [15:0]         mem_rd_data,
    output logic [15:0]         ir,
    output logic [NUM_EXEC-1:0] exec_start,
    input  logic [NUM_EXEC-1:0] exec_done,
    input  logic                exec_pc_inc,
    input  logic                pc_load,
    input  logic [PC_W-1:0]     pc_load_val,
    output logic [PC_W-1:0]     pc,
    output logic                busy,
    output logic                halted,
    output logic                fault,
    output logic [1:0]          fault_code,
    output logic [15:0]         instr_count
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_e              state, next_state;
    op_info_t            dec;
    op_cls_e             dec_cls;
    logic [NUM_EXEC-1:0] sel;
    logic                done_hit;
    logic [TMO_W-1:0]    tmo_cnt;

    logic       ir_load, ir_clear, cnt_clr, cnt_inc, retire, nop_inc, set_fault;
    logic [1:0] fault_code_nxt;

    // ir is stable from DECODE through WAIT_DONE, so decode straight from it.
    assign dec      = op_class(ir[15:12]);
    assign dec_cls  = (dec.cls == CLS_EXEC && int'(dec.idx) >= NUM_EXEC) ? CLS_ILLEGAL : dec.cls;
    assign sel      = NUM_EXEC'(1) << dec.idx;
    assign done_hit = |(exec_done & sel);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    always_comb begin
        next_state     = state;
        mem_rd_req     = 1'b0;
        exec_start     = '0;
        ir_load        = 1'b0;
        ir_clear       = 1'b0;
        cnt_clr        = 1'b0;
        cnt_inc        = 1'b0;
        retire         = 1'b0;
        nop_inc        = 1'b0;
        set_fault      = 1'b0;
        fault_code_nxt = FAULT_NONE;
        case (state)
            S_IDLE:       if (run) next_state = S_FETCH_REQ;
            S_FETCH_REQ: begin
                mem_rd_req = 1'b1;
                next_state = S_FETCH_WAIT;
            end
            S_FETCH_WAIT: if (mem_rd_valid) begin
                ir_load    = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                case (dec_cls)
                    CLS_NOP: begin
                        nop_inc    = 1'b1;
                        retire     = 1'b1;
                        next_state = run ? S_FETCH_REQ : S_IDLE;
                    end
                    CLS_HALT: next_state = S_HALTED;
                    CLS_EXEC: next_state = S_EXEC;
                    default: begin
                        set_fault      = 1'b1;
                        fault_code_nxt = FAULT_ILLEGAL;
                        next_state     = S_FAULT;
                    end
                endcase
            end
            S_EXEC: begin
                exec_start = sel;
                cnt_clr    = 1'b1;
                next_state = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (done_hit) begin
                    ir_clear   = 1'b1;
                    retire     = 1'b1;
                    next_state = run ? S_FETCH_REQ : S_IDLE;
                end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                    set_fault      = 1'b1;
                    fault_code_nxt = FAULT_TIMEOUT;
                    next_state     = S_FAULT;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_HALTED, S_FAULT: next_state = state;
            default:           next_state = S_IDLE;
        endcase
    end

    // tmo_cnt holds the number of cycles elapsed since the start pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir          <= 16'h0000;
            instr_count <= 16'd0;
            fault_code  <= FAULT_NONE;
            tmo_cnt     <= '0;
        end else begin
            if (ir_load)
                ir <= mem_rd_data;
            else if (ir_clear)
                ir <= 16'h0000;
            if (retire)
                instr_count <= instr_count + 16'd1;
            if (set_fault)
                fault_code <= fault_code_nxt;
            if (cnt_clr)
                tmo_cnt <= TMO_W'(1);
            else if (cnt_inc)
                tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    dispatch_pc_reg #(.PC_W(PC_W)) u_pc (
        .clk      (clk),
        .rst      (rst),
        .en       (!(state inside {S_HALTED, S_FAULT})),
        .load     (pc_load),
        .load_val (pc_load_val),
        .inc      (exec_pc_inc | nop_inc),
        .pc       (pc)
    );

    assign mem_addr = pc;
    assign busy     = !(state inside {S_IDLE, S_HALTED, S_FAULT});
    assign halted   = (state == S_HALTED);
    assign fault    = (state == S_FAULT);

endmodule
